// File: rtl/dot_matrix_pkg.sv
// Shared types, constants and pixel helpers for the 4x4 dot-matrix cursor controller.
package dot_matrix_pkg;

  localparam int unsigned MAT_DIM = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned PIX_W   = 2 * IDX_W;
  localparam int unsigned NPIX    = MAT_DIM * MAT_DIM;

  typedef enum logic [1:0] {StOff, StReady, StMove, StHold} state_e;
  typedef enum logic [1:0] {DirUp, DirRight, DirDown, DirLeft} dir_e;

  function automatic logic [PIX_W-1:0] pix_idx(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
    return PIX_W'(row) * PIX_W'(MAT_DIM) + PIX_W'(col);
  endfunction

  function automatic logic [NPIX-1:0] pix_mask(input logic [IDX_W-1:0] row,
                                               input logic [IDX_W-1:0] col);
    return NPIX'(1) << pix_idx(row, col);
  endfunction

endpackage

// File: rtl/dot_matrix_cursor_ctrl_scan.sv
// Row scanner: holds each row for SCAN_DIV cycles and drives one-hot row_sel with that row's
// frame bits on col_data. Outputs are zero while disabled.
module dot_matrix_scan
  import dot_matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NPIX-1:0]     frame,
  output logic [MAT_DIM-1:0]  row_sel,
  output logic [MAT_DIM-1:0]  col_data
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

  logic [DivW-1:0]  div_q;
  logic [IDX_W-1:0] row_q;
  logic [IDX_W-1:0] row_nxt;

  assign row_nxt = row_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_q    <= '0;
      row_q    <= '0;
      row_sel  <= '0;
      col_data <= '0;
    end else if (row_sel == '0) begin
      // First enabled cycle: start a full-length dwell on row 0.
      div_q    <= '0;
      row_q    <= '0;
      row_sel  <= MAT_DIM'(1);
      col_data <= frame[pix_idx(IDX_W'(0), IDX_W'(0)) +: MAT_DIM];
    end else if (div_q == DivMax) begin
      div_q    <= '0;
      row_q    <= row_nxt;
      row_sel  <= MAT_DIM'(1) << row_nxt;
      col_data <= frame[pix_idx(row_nxt, IDX_W'(0)) +: MAT_DIM];
    end else begin
      div_q    <= div_q + DivW'(1);
      col_data <= frame[pix_idx(row_q, IDX_W'(0)) +: MAT_DIM];
    end
  end

endmodule

// File: rtl/dot_matrix_cursor_ctrl.sv
// 4x4 dot-matrix cursor controller: button arbitration, wrap-around cursor, frame buffer, scan.
// Define DOT_MATRIX_TRAIL_EN to keep a trail of visited pixels in the frame.
module dot_matrix_cursor_ctrl
  import dot_matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned REPEAT_DLY = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               clr,
  output logic [MAT_DIM-1:0] row_sel,
  output logic [MAT_DIM-1:0] col_data,
  output logic [IDX_W-1:0]   cur_row,
  output logic [IDX_W-1:0]   cur_col,
  output logic [NPIX-1:0]    frame
);

  localparam int unsigned RptW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam logic [RptW-1:0] RptMax = RptW'(REPEAT_DLY - 1);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d, arb_dir;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d, mv_row, mv_col;
  logic [NPIX-1:0]  frame_q, frame_d;
  logic [RptW-1:0]  rpt_q, rpt_d;
  logic             btn_any;

  assign btn_any = up | down | left | right;

  always_comb begin
    if (up)         arb_dir = DirUp;
    else if (right) arb_dir = DirRight;
    else if (down)  arb_dir = DirDown;
    else            arb_dir = DirLeft;
  end

  always_comb begin
    mv_row = row_q;
    mv_col = col_q;
    unique case (dir_q)
      DirUp:    mv_row = row_q - IDX_W'(1);
      DirDown:  mv_row = row_q + IDX_W'(1);
      DirLeft:  mv_col = col_q - IDX_W'(1);
      DirRight: mv_col = col_q + IDX_W'(1);
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    row_d   = row_q;
    col_d   = col_q;
    frame_d = frame_q;
    rpt_d   = rpt_q;
    if (!power) begin
      state_d = StOff;
      row_d   = '0;
      col_d   = '0;
      frame_d = '0;
      rpt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StReady;
          frame_d = NPIX'(1);
        end
        StReady: begin
          rpt_d = '0;
          if (clr) frame_d = pix_mask(row_q, col_q);
          if (btn_any) begin
            dir_d   = arb_dir;
            state_d = StMove;
          end
        end
        StMove: begin
          row_d   = mv_row;
          col_d   = mv_col;
`ifdef DOT_MATRIX_TRAIL_EN
          frame_d = frame_q | pix_mask(mv_row, mv_col);
`else
          frame_d = pix_mask(mv_row, mv_col);
`endif
          if (clr) frame_d = pix_mask(mv_row, mv_col);
          rpt_d   = '0;
          state_d = StHold;
        end
        StHold: begin
          if (clr) frame_d = pix_mask(row_q, col_q);
          if (!btn_any) begin
            rpt_d   = '0;
            state_d = StReady;
          end else if (rpt_q == RptMax) begin
            dir_d   = arb_dir;
            state_d = StMove;
          end else begin
            rpt_d = rpt_q + RptW'(1);
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      dir_q   <= DirUp;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      rpt_q   <= rpt_d;
    end
  end

  assign cur_row = row_q;
  assign cur_col = col_q;
  assign frame   = frame_q;

  // Scanner follows the next state and frame so it goes dark on the same edge as power drop.
  dot_matrix_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .en       (state_d != StOff),
    .frame    (frame_d),
    .row_sel  (row_sel),
    .col_data (col_data)
  );

endmodule

// File: tb/tb_dot_matrix_cursor_ctrl.sv
// Directed self-checking bench for dot_matrix_cursor_ctrl (SCAN_DIV=4, REPEAT_DLY=8).
module tb_dot_matrix_cursor_ctrl;

`ifdef DOT_MATRIX_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, power, up, down, left, right, clr;
  logic [3:0]  row_sel, col_data;
  logic [1:0]  cur_row, cur_col;
  logic [15:0] frame;

  int n_cmp = 0;
  int n_err = 0;

  dot_matrix_cursor_ctrl #(
    .SCAN_DIV   (4),
    .REPEAT_DLY (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .power    (power),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .clr      (clr),
    .row_sel  (row_sel),
    .col_data (col_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // b = {up, right, down, left}; press one cycle, then let MOVE and HOLD->READY complete
  task automatic pulse(input logic [3:0] b);
    {up, right, down, left} = b;
    tick();
    {up, right, down, left} = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_rs, exp_cd;
    rst = 1'b1; power = 1'b1;
    tick(); tick();
    n_cmp++;
    if (frame !== 16'h0000 || row_sel !== 4'b0000 || col_data !== 4'b0000 ||
        cur_row !== 2'd0 || cur_col !== 2'd0) begin
      $display("FAIL reset_vals: frame=%h row_sel=%b col=%b cur=(%0d,%0d) want 0000/0000/0000/(0,0)",
               frame, row_sel, col_data, cur_row, cur_col);
      n_err++;
    end
    rst = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      exp_rs = 4'b0001 << ((t / 4) % 4);
      exp_cd = (t < 4) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (row_sel !== exp_rs || col_data !== exp_cd) begin
        $display("FAIL scan_t%0d: row_sel=%b col=%b want %b/%b", t, row_sel, col_data,
                 exp_rs, exp_cd);
        n_err++;
      end
    end
    n_cmp++;
    if (frame !== 16'h0001 || cur_row !== 2'd0 || cur_col !== 2'd0) begin
      $display("FAIL ready_frame: frame=%h cur=(%0d,%0d) want 0001 (0,0)", frame, cur_row,
               cur_col);
      n_err++;
    end
  endtask

  task automatic test_up_wrap();
    up = 1'b1;
    tick();
    up = 1'b0;
    n_cmp++;
    if (cur_row !== 2'd0 || frame !== 16'h0001) begin
      $display("FAIL up_latency_k: cur_row=%0d frame=%h want 0 0001", cur_row, frame);
      n_err++;
    end
    tick();
    n_cmp++;
    if (cur_row !== 2'd3 || cur_col !== 2'd0 || frame !== (TRAIL ? 16'h1001 : 16'h1000)) begin
      $display("FAIL up_wrap: cur=(%0d,%0d) frame=%h want (3,0) %h", cur_row, cur_col, frame,
               TRAIL ? 16'h1001 : 16'h1000);
      n_err++;
    end
    tick();
    pulse(4'b0010);
    n_cmp++;
    if (cur_row !== 2'd0 || frame !== (TRAIL ? 16'h1001 : 16'h0001)) begin
      $display("FAIL down_wrap: cur_row=%0d frame=%h want 0 %h", cur_row, frame,
               TRAIL ? 16'h1001 : 16'h0001);
      n_err++;
    end
  endtask

  task automatic test_hold_repeat();
    logic [1:0] exp_c;
    right = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_c = (i >= 20) ? 2'd3 : (i >= 11) ? 2'd2 : (i >= 2) ? 2'd1 : 2'd0;
      n_cmp++;
      if (cur_col !== exp_c || cur_row !== 2'd0) begin
        $display("FAIL hold_right_t%0d: cur=(%0d,%0d) want (0,%0d)", i, cur_row, cur_col, exp_c);
        n_err++;
      end
    end
    right = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (cur_col !== 2'd3 || frame !== (TRAIL ? 16'h100F : 16'h0008)) begin
      $display("FAIL hold_release: cur_col=%0d frame=%h want 3 %h", cur_col, frame,
               TRAIL ? 16'h100F : 16'h0008);
      n_err++;
    end
  endtask

  task automatic test_priority();
    pulse(4'b0010);
    pulse(4'b0010);
    pulse(4'b0001);
    n_cmp++;
    if (cur_row !== 2'd2 || cur_col !== 2'd2 || frame !== (TRAIL ? 16'h1C8F : 16'h0400)) begin
      $display("FAIL reach_2_2: cur=(%0d,%0d) frame=%h want (2,2) %h", cur_row, cur_col, frame,
               TRAIL ? 16'h1C8F : 16'h0400);
      n_err++;
    end
    pulse(4'b1011);
    tick(); tick();
    n_cmp++;
    if (cur_row !== 2'd1 || cur_col !== 2'd2 || frame !== (TRAIL ? 16'h1CCF : 16'h0040)) begin
      $display("FAIL multi_btn: cur=(%0d,%0d) frame=%h want (1,2) %h", cur_row, cur_col, frame,
               TRAIL ? 16'h1CCF : 16'h0040);
      n_err++;
    end
  endtask

  task automatic test_clr();
    pulse(4'b0001);
    n_cmp++;
    if (cur_col !== 2'd1 || frame !== (TRAIL ? 16'h1CEF : 16'h0020)) begin
      $display("FAIL pre_clr: cur_col=%0d frame=%h want 1 %h", cur_col, frame,
               TRAIL ? 16'h1CEF : 16'h0020);
      n_err++;
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if (frame !== 16'h0020) begin
      $display("FAIL clr_ready: frame=%h want 0020", frame);
      n_err++;
    end
    right = 1'b1;
    tick();
    right = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    n_cmp++;
    if (cur_row !== 2'd1 || cur_col !== 2'd2 || frame !== 16'h0040) begin
      $display("FAIL clr_move: cur=(%0d,%0d) frame=%h want (1,2) 0040", cur_row, cur_col, frame);
      n_err++;
    end
  endtask

  task automatic test_power();
    up = 1'b1;
    tick(); tick(); tick();
    power = 1'b0;
    tick();
    up = 1'b0;
    n_cmp++;
    if (row_sel !== 4'b0000 || col_data !== 4'b0000 || frame !== 16'h0000 ||
        cur_row !== 2'd0 || cur_col !== 2'd0) begin
      $display("FAIL power_drop: row_sel=%b col=%b frame=%h cur=(%0d,%0d) want zeros",
               row_sel, col_data, frame, cur_row, cur_col);
      n_err++;
    end
    power = 1'b1;
    tick();
    n_cmp++;
    if (frame !== 16'h0001 || row_sel !== 4'b0001 || col_data !== 4'b0001) begin
      $display("FAIL power_up: frame=%h row_sel=%b col=%b want 0001/0001/0001", frame, row_sel,
               col_data);
      n_err++;
    end
    pulse(4'b0001);
    n_cmp++;
    if (cur_col !== 2'd3 || frame !== (TRAIL ? 16'h0009 : 16'h0008)) begin
      $display("FAIL left_wrap: cur_col=%0d frame=%h want 3 %h", cur_col, frame,
               TRAIL ? 16'h0009 : 16'h0008);
      n_err++;
    end
  endtask

  task automatic test_rst_mid_move();
    down = 1'b1;
    tick();
    down = 1'b0; rst = 1'b1;
    tick();
    n_cmp++;
    if (cur_row !== 2'd0 || cur_col !== 2'd0 || frame !== 16'h0000 || row_sel !== 4'b0000) begin
      $display("FAIL rst_mid: cur=(%0d,%0d) frame=%h row_sel=%b want zeros", cur_row, cur_col,
               frame, row_sel);
      n_err++;
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (frame !== 16'h0001 || cur_row !== 2'd0) begin
      $display("FAIL rst_recover: frame=%h cur_row=%0d want 0001 0", frame, cur_row);
      n_err++;
    end
  endtask

  initial begin
    rst = 1'b1; power = 1'b0; up = 1'b0; down = 1'b0;
    left = 1'b0; right = 1'b0; clr = 1'b0;
    test_reset();
    test_up_wrap();
    test_hold_repeat();
    test_priority();
    test_clr();
    test_power();
    test_rst_mid_move();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
